// File: rtl/proc_core.sv
// -----------------------------------------------------------------------------
// proc_core -- single-cycle 32-bit RISC core
//
// Fetches one instruction per clock from an external instruction memory,
// decodes and executes it combinationally, and drives an external 32x32
// register file (r0 is hardwired to zero outside this block) and a data
// memory / MMIO window reached through ordinary lw/sw.
//
// Optional build macro: PROC_OVF_STATUS_EN
//   When defined, a signed overflow on add, addi or sub writes a status code
//   to r30 (add=1, addi=2, sub=3) instead of writing rd.
//   When undefined, overflowing results wrap and are written to rd.
//
// Ports:
//   clock             in   master clock, PC updates on the rising edge
//   reset             in   synchronous active-low reset
//   address_imem      out  current PC (PC_WIDTH bits)
//   q_imem            in   instruction at address_imem
//   address_dmem      out  load/store address (DADDR_WIDTH bits), 0 otherwise
//   data              out  store data (register port B value)
//   wren              out  data memory / MMIO write enable (sw only)
//   q_dmem            in   load data
//   ctrl_writeEnable  out  register file write enable (never for r0)
//   ctrl_writeReg     out  register file destination
//   ctrl_readRegA     out  register file read port A select
//   ctrl_readRegB     out  register file read port B select
//   data_writeReg     out  register file write data
//   data_readRegA     in   read port A data
//   data_readRegB     in   read port B data
// -----------------------------------------------------------------------------
module proc_core #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  DADDR_WIDTH = 17,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    address_imem,
    input  logic [31:0]            q_imem,
    output logic [DADDR_WIDTH-1:0] address_dmem,
    output logic [31:0]            data,
    output logic                   wren,
    input  logic [31:0]            q_dmem,
    output logic                   ctrl_writeEnable,
    output logic [4:0]             ctrl_writeReg,
    output logic [4:0]             ctrl_readRegA,
    output logic [4:0]             ctrl_readRegB,
    output logic [31:0]            data_writeReg,
    input  logic [31:0]            data_readRegA,
    input  logic [31:0]            data_readRegB
);

    // -------------------------------------------------------------------------
    // Instruction encodings
    // -------------------------------------------------------------------------
    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_J     = 5'b00001,
        OP_BNE   = 5'b00010,
        OP_JAL   = 5'b00011,
        OP_JR    = 5'b00100,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000,
        OP_SETX  = 5'b10101,
        OP_BEX   = 5'b10110
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101
    } aluop_e;

    localparam logic [4:0] R_ZERO   = 5'd0;
    localparam logic [4:0] R_STATUS = 5'd30;
    localparam logic [4:0] R_LINK   = 5'd31;

    // -------------------------------------------------------------------------
    // Field extraction
    // -------------------------------------------------------------------------
    opcode_e     opcode;
    aluop_e      aluop;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic [31:0] target_ext;

    assign opcode     = opcode_e'(q_imem[31:27]);
    assign rd         = q_imem[26:22];
    assign rs         = q_imem[21:17];
    assign rt         = q_imem[16:12];
    assign shamt      = q_imem[11:7];
    assign aluop      = aluop_e'(q_imem[6:2]);
    assign imm_ext    = {{15{q_imem[16]}}, q_imem[16:0]};
    assign target_ext = {5'b0, q_imem[26:0]};

    // -------------------------------------------------------------------------
    // Register file read-port selection
    // -------------------------------------------------------------------------
    // Port A normally carries rs; jr needs rd as its target and bex tests r30.
    // Port B carries rt for R-type; sw and the compare-branches need rd there
    // (sw stores rd, branches compare rd against rs).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves it unassigned and infers a latch.
        ctrl_readRegA = rs;
        ctrl_readRegB = rt;
        case (opcode)
            OP_JR:                 ctrl_readRegA = rd;
            OP_BEX:                ctrl_readRegA = R_STATUS;
            OP_SW, OP_BNE, OP_BLT: ctrl_readRegB = rd;
            default:               ;
        endcase
    end

    logic [31:0] op_a;
    logic [31:0] op_b;

    assign op_a = data_readRegA;
    assign op_b = data_readRegB;

    // -------------------------------------------------------------------------
    // Arithmetic
    // -------------------------------------------------------------------------
    logic [31:0] sum_ab;
    logic [31:0] diff_ab;
    logic [31:0] sum_imm;

    assign sum_ab  = op_a + op_b;
    assign diff_ab = op_a - op_b;
    // Shared by addi and by the lw/sw effective address.
    assign sum_imm = op_a + imm_ext;

`ifdef PROC_OVF_STATUS_EN
    logic add_ovf;
    logic sub_ovf;
    logic addi_ovf;

    // Signed overflow: the operands (after negating b for sub) share a sign
    // that the wrapped result does not.
    assign add_ovf  = (op_a[31] == op_b[31])    && (sum_ab[31]  != op_a[31]);
    assign sub_ovf  = (op_a[31] != op_b[31])    && (diff_ab[31] != op_a[31]);
    assign addi_ovf = (op_a[31] == imm_ext[31]) && (sum_imm[31] != op_a[31]);
`endif

    // R-type ALU. Shifts act on rs (port A) by the immediate shamt field.
    logic        alu_valid;
    logic [31:0] alu_result;

    always_comb begin
        alu_valid  = 1'b1;
        alu_result = sum_ab;
        case (aluop)
            ALU_ADD: alu_result = sum_ab;
            ALU_SUB: alu_result = diff_ab;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_SLL: alu_result = op_a << shamt;
            ALU_SRA: alu_result = $signed(op_a) >>> shamt;
            default: alu_valid  = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Program counter
    // -------------------------------------------------------------------------
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] jmp_target;

    // All PC arithmetic wraps modulo 2^PC_WIDTH; targets are truncated.
    assign pc_plus1   = pc_q + PC_WIDTH'(1);
    assign br_target  = pc_plus1 + imm_ext[PC_WIDTH-1:0];
    assign jmp_target = target_ext[PC_WIDTH-1:0];

    // -------------------------------------------------------------------------
    // Execute / writeback control
    // -------------------------------------------------------------------------
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        is_store;
    logic        is_mem;

    always_comb begin
        wr_en    = 1'b0;
        wr_reg   = rd;
        wr_data  = alu_result;
        is_store = 1'b0;
        is_mem   = 1'b0;
        pc_d     = pc_plus1;

        case (opcode)
            OP_RTYPE: begin
                // Unassigned aluop values leave alu_valid low: no write.
                wr_en = alu_valid;
`ifdef PROC_OVF_STATUS_EN
                if (aluop == ALU_ADD && add_ovf) begin
                    wr_reg  = R_STATUS;
                    wr_data = 32'd1;
                end else if (aluop == ALU_SUB && sub_ovf) begin
                    wr_reg  = R_STATUS;
                    wr_data = 32'd3;
                end
`endif
            end

            OP_ADDI: begin
                wr_en   = 1'b1;
                wr_data = sum_imm;
`ifdef PROC_OVF_STATUS_EN
                if (addi_ovf) begin
                    wr_reg  = R_STATUS;
                    wr_data = 32'd2;
                end
`endif
            end

            OP_SW: begin
                is_store = 1'b1;
                is_mem   = 1'b1;
            end

            OP_LW: begin
                is_mem  = 1'b1;
                wr_en   = 1'b1;
                wr_data = q_dmem;
            end

            // Port B holds rd and port A holds rs for both compare-branches.
            OP_BNE: begin
                if (op_b != op_a) pc_d = br_target;
            end

            OP_BLT: begin
                if ($signed(op_b) < $signed(op_a)) pc_d = br_target;
            end

            OP_J: begin
                pc_d = jmp_target;
            end

            OP_JAL: begin
                wr_en   = 1'b1;
                wr_reg  = R_LINK;
                wr_data = {{(32-PC_WIDTH){1'b0}}, pc_plus1};
                pc_d    = jmp_target;
            end

            OP_JR: begin
                pc_d = op_a[PC_WIDTH-1:0];
            end

            OP_SETX: begin
                wr_en   = 1'b1;
                wr_reg  = R_STATUS;
                wr_data = target_ext;
            end

            // Port A is steered to r30 for bex.
            OP_BEX: begin
                if (op_a != '0) pc_d = jmp_target;
            end

            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // The PC is the only state held here; the register file and memories are
    // external, so there is no storage array to reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // While reset is low the instruction is aborted: both write strobes are
    // held off so nothing architectural changes.
    assign address_imem     = pc_q;
    assign address_dmem     = is_mem ? sum_imm[DADDR_WIDTH-1:0] : '0;
    assign data             = op_b;
    assign wren             = reset & is_store;
    assign ctrl_writeEnable = reset & wr_en & (wr_reg != R_ZERO);
    assign ctrl_writeReg    = wr_reg;
    assign data_writeReg    = wr_data;

endmodule

// File: tb/tb_proc_core.sv
// -----------------------------------------------------------------------------
// tb_proc_core -- self-checking bench for proc_core
//
// The bench plays instruction memory (drives q_imem directly each cycle), data
// memory (drives q_dmem) and the register file (array written on the falling
// edge from the DUT write strobes). An architectural model holds its own
// register array and PC and predicts every cycle's strobes, addresses and
// next PC from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_proc_core;

`ifdef PROC_OVF_STATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [16:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    proc_core dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .address_dmem     (address_dmem),
        .data             (data),
        .wren             (wren),
        .q_dmem           (q_dmem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment register file: r0 reads zero, writes on the falling edge.
    logic [31:0] env_regs [32] = '{default: 32'd0};

    assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : env_regs[ctrl_readRegA];
    assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : env_regs[ctrl_readRegB];

    always @(negedge clock) begin
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0)
            env_regs[ctrl_writeReg] <= data_writeReg;
    end

    // Architectural model state and per-instruction predictions.
    logic [31:0] m_regs [32] = '{default: 32'd0};
    int          m_pc = 0;
    logic        e_we;
    logic        e_wren;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    int          e_npc;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic bit out_of_range(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Encoders
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] fn);
        return {OP_R, rd, rs, rt, sh, fn, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input int imm);
        logic [31:0] t;
        t = imm;
        return {op, rd, rs, t[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input int tgt);
        logic [31:0] t;
        t = tgt;
        return {op, t[26:0]};
    endfunction

    // Predict the effect of one instruction from the model state.
    task automatic model(input logic [31:0] ins, input logic [31:0] dq, input logic rst_v);
        logic [4:0]  op, rd, rs, rt, sh, fn;
        logic [31:0] va, vd, vt, tv, ea;
        longint      imm_l, res;
        int          code;
        op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17];
        rt = ins[16:12]; sh = ins[11:7];  fn = ins[6:2];
        va = m_regs[rs]; vd = m_regs[rd]; vt = m_regs[rt];
        imm_l = longint'($signed(ins[16:0]));
        tv    = {5'd0, ins[26:0]};
        ea    = 32'(sx(va) + imm_l);
        res   = 0;
        code  = 0;
        e_we = 1'b0; e_wren = 1'b0; e_wreg = rd; e_wdata = 32'd0;
        e_addr = 32'd0; e_data = vd; e_npc = (m_pc + 1) % 4096;
        case (op)
            OP_R: begin
                e_we = 1'b1;
                case (fn)
                    5'd0: begin res = sx(va) + sx(vt); if (out_of_range(res)) code = 1; end
                    5'd1: begin res = sx(va) - sx(vt); if (out_of_range(res)) code = 3; end
                    5'd2: res = longint'(va & vt);
                    5'd3: res = longint'(va | vt);
                    5'd4: res = longint'(va) << sh;
                    5'd5: res = sx(va) >>> sh;
                    default: e_we = 1'b0;
                endcase
                e_wdata = res[31:0];
            end
            OP_ADDI: begin
                res = sx(va) + imm_l;
                if (out_of_range(res)) code = 2;
                e_we = 1'b1; e_wdata = res[31:0];
            end
            OP_SW: begin e_wren = 1'b1; e_addr = {15'd0, ea[16:0]}; end
            OP_LW: begin e_addr = {15'd0, ea[16:0]}; e_we = 1'b1; e_wdata = dq; end
            OP_BNE:  if (vd != va) e_npc = (m_pc + 1 + int'(imm_l)) & 4095;
            OP_BLT:  if (sx(vd) < sx(va)) e_npc = (m_pc + 1 + int'(imm_l)) & 4095;
            OP_J:    e_npc = int'(tv & 32'd4095);
            OP_JAL: begin
                e_we = 1'b1; e_wreg = 5'd31; e_wdata = 32'((m_pc + 1) % 4096);
                e_npc = int'(tv & 32'd4095);
            end
            OP_JR:   e_npc = int'(vd & 32'd4095);
            OP_SETX: begin e_we = 1'b1; e_wreg = 5'd30; e_wdata = tv; end
            OP_BEX:  if (m_regs[30] != 32'd0) e_npc = int'(tv & 32'd4095);
            default: ;
        endcase
        if (OVF_EN && code != 0) begin
            e_wreg  = 5'd30;
            e_wdata = 32'(code);
        end
        if (e_wreg == 5'd0) e_we = 1'b0;
        if (!rst_v) begin
            e_we = 1'b0; e_wren = 1'b0; e_npc = 0;
        end
    endtask

    // Drive one instruction (just after a rising edge) and check its
    // combinational outputs before the falling edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] dq,
                         input logic rst_v, input string tag);
        q_imem = ins;
        q_dmem = dq;
        reset  = rst_v;
        #2;
        model(ins, dq, rst_v);
        check({tag, ".we"},   32'(ctrl_writeEnable), 32'(e_we));
        check({tag, ".wren"}, 32'(wren), 32'(e_wren));
        check({tag, ".addr"}, 32'(address_dmem), e_addr);
        if (e_we) begin
            check({tag, ".wreg"},  32'(ctrl_writeReg), 32'(e_wreg));
            check({tag, ".wdata"}, data_writeReg, e_wdata);
        end
        if (e_wren) check({tag, ".data"}, data, e_data);
    endtask

    // Cross the rising edge, commit the model and check the new PC.
    task automatic retire(input string tag);
        @(posedge clock);
        #1;
        if (e_we) m_regs[e_wreg] = e_wdata;
        m_pc = e_npc;
        check({tag, ".pc"}, 32'(address_imem), 32'(m_pc));
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] dq,
                        input logic rst_v, input string tag);
        issue(ins, dq, rst_v, tag);
        retire(tag);
    endtask

    logic [4:0] op_pool [12] = '{OP_R, OP_R, OP_ADDI, OP_SW, OP_LW, OP_BNE,
                                 OP_BLT, OP_J, OP_JAL, OP_JR, OP_SETX, OP_BEX};

    initial begin
        logic [31:0] r_ins;
        logic [31:0] r_rand;
        logic [4:0]  r_op;
        logic        r_rst;
        int          k;

        reset  = 1'b0;
        q_imem = 32'd0;
        q_dmem = 32'd0;
        @(posedge clock);
        #1;

        // Reset held two cycles with a writing instruction present.
        step(enc_i(OP_ADDI, 5'd1, 5'd0, 5), 32'd0, 1'b0, "rst0");
        step(enc_i(OP_ADDI, 5'd1, 5'd0, 5), 32'd0, 1'b0, "rst1");
        check("rst.pc_zero", 32'(address_imem), 32'd0);

        // First instruction out of reset.
        issue(enc_i(OP_ADDI, 5'd1, 5'd0, 5), 32'd0, 1'b1, "addi5");
        check("addi5.wreg_const",  32'(ctrl_writeReg), 32'd1);
        check("addi5.wdata_const", data_writeReg, 32'd5);
        retire("addi5");
        check("addi5.pc_const", 32'(address_imem), 32'd1);

        // R-type with r1=7, r2=3.
        step(enc_i(OP_ADDI, 5'd1, 5'd0, 7), 32'd0, 1'b1, "set_r1");
        step(enc_i(OP_ADDI, 5'd2, 5'd0, 3), 32'd0, 1'b1, "set_r2");
        issue(enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd0), 32'd0, 1'b1, "add");
        check("add.const", data_writeReg, 32'd10);
        retire("add");
        issue(enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd1), 32'd0, 1'b1, "sub");
        check("sub.const", data_writeReg, 32'd4);
        retire("sub");
        issue(enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd2), 32'd0, 1'b1, "and");
        check("and.const", data_writeReg, 32'd3);
        retire("and");
        issue(enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd3), 32'd0, 1'b1, "or");
        check("or.const", data_writeReg, 32'd7);
        retire("or");
        issue(enc_r(5'd6, 5'd1, 5'd0, 5'd4, 5'd4), 32'd0, 1'b1, "sll");
        check("sll.const", data_writeReg, 32'h70);
        retire("sll");
        step(enc_i(OP_ADDI, 5'd7, 5'd0, 1), 32'd0, 1'b1, "set_r7");
        step(enc_r(5'd7, 5'd7, 5'd0, 5'd31, 5'd4), 32'd0, 1'b1, "sll31");
        issue(enc_r(5'd8, 5'd7, 5'd0, 5'd4, 5'd5), 32'd0, 1'b1, "sra");
        check("sra.const", data_writeReg, 32'hF800_0000);
        retire("sra");
        issue(enc_r(5'd8, 5'd1, 5'd2, 5'd0, 5'd9), 32'd0, 1'b1, "rnop");
        check("rnop.we_const", 32'(ctrl_writeEnable), 32'd0);
        retire("rnop");

        // Memory access.
        step(enc_i(OP_ADDI, 5'd3, 5'd0, 260), 32'd0, 1'b1, "set_r3");
        issue(enc_i(OP_SW, 5'd3, 5'd0, 4200), 32'd0, 1'b1, "sw");
        check("sw.addr_const", 32'(address_dmem), 32'd4200);
        check("sw.data_const", data, 32'd260);
        check("sw.wren_const", 32'(wren), 32'd1);
        retire("sw");
        issue(enc_i(OP_LW, 5'd4, 5'd0, 4100), 32'd2, 1'b1, "lw");
        check("lw.wreg_const",  32'(ctrl_writeReg), 32'd4);
        check("lw.wdata_const", data_writeReg, 32'd2);
        check("lw.wren_const",  32'(wren), 32'd0);
        retire("lw");

        // Branches.
        step(enc_j(OP_J, 10), 32'd0, 1'b1, "j10");
        step(enc_i(OP_BNE, 5'd1, 5'd2, -3), 32'd0, 1'b1, "bne_taken");
        check("bne_taken.pc_const", 32'(address_imem), 32'd8);
        step(enc_i(OP_BNE, 5'd1, 5'd1, 5), 32'd0, 1'b1, "bne_equal");
        check("bne_equal.pc_const", 32'(address_imem), 32'd9);
        step(enc_i(OP_ADDI, 5'd9, 5'd0, -1), 32'd0, 1'b1, "set_r9");
        step(enc_i(OP_ADDI, 5'd10, 5'd0, 1), 32'd0, 1'b1, "set_r10");
        step(enc_i(OP_BLT, 5'd9, 5'd10, 5), 32'd0, 1'b1, "blt");
        check("blt.pc_const", 32'(address_imem), 32'd17);
        step(enc_i(OP_BNE, 5'd1, 5'd2, -1), 32'd0, 1'b1, "bself");
        check("bself.pc_const", 32'(address_imem), 32'd17);

        // Jumps.
        step(enc_j(OP_J, 5), 32'd0, 1'b1, "j5");
        issue(enc_j(OP_JAL, 40), 32'd0, 1'b1, "jal");
        check("jal.wreg_const",  32'(ctrl_writeReg), 32'd31);
        check("jal.wdata_const", data_writeReg, 32'd6);
        retire("jal");
        check("jal.pc_const", 32'(address_imem), 32'd40);
        step(enc_i(OP_JR, 5'd31, 5'd0, 0), 32'd0, 1'b1, "jr");
        check("jr.pc_const", 32'(address_imem), 32'd6);
        step(enc_j(OP_SETX, 9), 32'd0, 1'b1, "setx9");
        step(enc_j(OP_BEX, 20), 32'd0, 1'b1, "bex_taken");
        check("bex_taken.pc_const", 32'(address_imem), 32'd20);
        step(enc_j(OP_SETX, 0), 32'd0, 1'b1, "setx0");
        step(enc_j(OP_BEX, 20), 32'd0, 1'b1, "bex_not");
        check("bex_not.pc_const", 32'(address_imem), 32'd22);

        // Overflow and r0.
        step(enc_i(OP_LW, 5'd12, 5'd0, 0), 32'h7FFF_FFFF, 1'b1, "ld_max");
        issue(enc_r(5'd13, 5'd12, 5'd10, 5'd0, 5'd0), 32'd0, 1'b1, "ovf");
        check("ovf.wreg_const",  32'(ctrl_writeReg), OVF_EN ? 32'd30 : 32'd13);
        check("ovf.wdata_const", data_writeReg, OVF_EN ? 32'd1 : 32'h8000_0000);
        retire("ovf");
        issue(enc_i(OP_ADDI, 5'd0, 5'd0, 7), 32'd0, 1'b1, "r0");
        check("r0.we_const", 32'(ctrl_writeEnable), 32'd0);
        retire("r0");

        // Reset asserted mid-program aborts a store.
        issue(enc_i(OP_SW, 5'd3, 5'd0, 4200), 32'd0, 1'b0, "abort");
        check("abort.wren_const", 32'(wren), 32'd0);
        retire("abort");
        check("abort.pc_const", 32'(address_imem), 32'd0);

        // Randomised program: load random register contents, then mix.
        for (int i = 1; i < 32; i++)
            step(enc_i(OP_LW, 5'(i), 5'd0, 0), $urandom, 1'b1, "rinit");
        for (int n = 0; n < 400; n++) begin
            r_rand = $urandom;
            k      = $urandom_range(0, 12);
            r_op   = (k == 12) ? r_rand[31:27] : op_pool[k];
            r_ins  = {r_op, r_rand[26:0]};
            if (r_op == OP_R) r_ins[6:2] = 5'($urandom_range(0, 7));
            r_rst  = ($urandom_range(0, 39) != 0);
            step(r_ins, $urandom, r_rst, "rand");
        end
        step(32'd0, 32'd0, 1'b1, "drain");

        for (int i = 0; i < 32; i++)
            check($sformatf("regfile.r%0d", i), env_regs[i], m_regs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
